// File: rtl/ascon_mask_encoder.sv
// Splits a clear word into d+1 Boolean shares using d*W bits of fresh randomness.
// Latency: NB rng beats + 1 combine cycle. in_ready is low while a word is in flight; output holds until out_ready.
module ascon_mask_encoder #(
   parameter int d          = 2,
   parameter int num_shares = 3,
   parameter int W          = 64,
   parameter int RW         = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_data,
   input  logic                    rnd_valid,
   output logic                    rnd_ready,
   input  logic [RW-1:0]           rnd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [num_shares*W-1:0] out_shares,
   output logic                    busy
);

   localparam int NB = d * W / RW;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, COMBINE, OUTPUT} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_data;
   logic [W-1:0]   r_share0;
   logic [W-1:0]   w_share0;
   logic [d*W-1:0] r_rnd;
   logic           w_in_xfer;
   logic           w_rnd_xfer;
   logic           w_out_xfer;

   assign w_in_xfer  = in_valid  & in_ready;
   assign w_rnd_xfer = rnd_valid & rnd_ready;
   assign w_out_xfer = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         IDLE: begin
            busy     = 1'b0;
            // Held low for as long as reset is asserted, not just at the edge.
            in_ready = ~rst;
            if (w_in_xfer) w_next = COLLECT;
         end
         COLLECT: begin
            rnd_ready = 1'b1;
            if (rnd_valid && r_cnt == CW'(NB - 1)) w_next = COMBINE;
         end
         COMBINE: w_next = OUTPUT;
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_share0 = r_data;
      for (int j = 0; j < d; j++) w_share0 ^= r_rnd[j*W +: W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_data   <= '0;
         r_rnd    <= '0;
         r_share0 <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_xfer) begin
                  r_data <= in_data;
                  r_cnt  <= '0;
               end
            end
            COLLECT: begin
               if (w_rnd_xfer) begin
                  r_rnd[int'(r_cnt)*RW +: RW] <= rnd_data;
                  r_cnt                       <= r_cnt + CW'(1);
               end
            end
            COMBINE: r_share0 <= w_share0;
            OUTPUT: begin
               // Wipe secret material once the shares have left.
               if (w_out_xfer) begin
                  r_data   <= '0;
                  r_rnd    <= '0;
                  r_share0 <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_shares = (r_state == OUTPUT) ? {r_rnd, r_share0} : '0;

endmodule

// File: tb/tb_ascon_mask_encoder.sv
// Randomized and directed self-checking bench for ascon_mask_encoder (default parameters).
module tb_ascon_mask_encoder;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [63:0]  in_data;
   logic         rnd_valid, rnd_ready;
   logic [31:0]  rnd_data;
   logic         out_valid, out_ready;
   logic [191:0] out_shares;
   logic         busy;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [63:0]  GOLD_DATA   = 64'h0123456789ABCDEF;
   localparam logic [127:0] GOLD_BEATS  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [191:0] GOLD_SHARES = {64'h4444444433333333, 64'h2222222211111111, 64'h67452301AB89EFCD};

   always #5 clk = ~clk;

   ascon_mask_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .rnd_data   (rnd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_shares (out_shares),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // One word through the encoder: optional rng stall after beat stall_at, then bp cycles of output backpressure.
   task automatic do_word(input string tag, input logic [63:0] data, input logic [127:0] beats,
                          input logic [191:0] exp, input int stall_at, input int stall_len, input int bp);
      int k;
      int e;
      int st;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      check({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      k = 0; e = 0; st = 0;
      while (!out_valid && e < 50) begin
         if (k == stall_at && st < stall_len) begin
            rnd_valid = 1'b0;
            st++;
         end else begin
            rnd_valid = 1'b1;
            rnd_data  = (k < 4) ? beats[k*32 +: 32] : $urandom;
         end
         if (rnd_valid && rnd_ready) k++;
         @(negedge clk);
         e++;
      end
      check({tag, "_latency"}, e, 5 + stall_len);
      check({tag, "_beats"}, k, 4);
      check({tag, "_shares"}, out_shares, exp);
      for (int i = 0; i < bp; i++) begin
         check({tag, "_bp_stable"}, out_shares, exp);
         check({tag, "_bp_valid"}, out_valid, 1);
         check({tag, "_bp_in_ready"}, in_ready, 0);
         check({tag, "_bp_rnd_ready"}, rnd_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      rnd_valid = 1'b0;
      check({tag, "_post_valid"}, out_valid, 0);
      check({tag, "_post_zero"}, out_shares, 0);
      check({tag, "_post_in_ready"}, in_ready, 1);
      check({tag, "_post_busy"}, busy, 0);
   endtask

   initial begin
      logic         inflight;
      logic [63:0]  m_data;
      logic [127:0] m_beats;
      int           m_nb;
      logic         m_seen;
      int           words;
      int           cycles;
      logic [191:0] m_exp;

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      rnd_valid = 1'b0; rnd_data = '0; out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_rnd_ready", rnd_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_shares", out_shares, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel_in_ready", in_ready, 1);
      check("rel_busy", busy, 0);

      do_word("golden", GOLD_DATA, GOLD_BEATS, GOLD_SHARES, 0, 0, 0);
      do_word("stall", GOLD_DATA, GOLD_BEATS, GOLD_SHARES, 1, 3, 0);
      do_word("bp", GOLD_DATA, GOLD_BEATS, GOLD_SHARES, 0, 0, 5);

      // Abort a word after two beats with a reset between clock edges.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 64'hDEADBEEFCAFEF00D;
      @(negedge clk);
      in_valid  = 1'b0;
      rnd_valid = 1'b1;
      rnd_data  = 32'hAAAAAAAA;
      @(negedge clk);
      rnd_data  = 32'h55555555;
      @(negedge clk);
      rnd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_rnd_ready", rnd_ready, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_shares", out_shares, 0);
      @(negedge clk);
      rst = 1'b0;
      do_word("after_rst", GOLD_DATA, GOLD_BEATS, GOLD_SHARES, 0, 0, 0);

      // Random traffic against a word-level model.
      inflight = 1'b0; m_data = '0; m_beats = '0; m_nb = 0; m_seen = 1'b0;
      words = 0; cycles = 0;
      while (words < 1000 && cycles < 60000) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = {$urandom, $urandom};
         rnd_valid = ($urandom_range(0, 3) != 0);
         rnd_data  = $urandom;
         out_ready = ($urandom_range(0, 1) == 1);
         check("rand_in_ready", in_ready, !inflight);
         if (out_valid && !m_seen) begin
            m_seen = 1'b1;
            m_exp  = {m_beats, m_data ^ m_beats[63:0] ^ m_beats[127:64]};
            check("rand_out_inflight", inflight, 1);
            check("rand_nbeats", m_nb, 4);
            check("rand_shares", out_shares, m_exp);
            check("rand_recombine", out_shares[63:0] ^ out_shares[127:64] ^ out_shares[191:128], m_data);
         end
         if (rnd_valid && rnd_ready) begin
            check("rand_rnd_window", inflight && m_nb < 4, 1);
            if (m_nb < 4) m_beats[m_nb*32 +: 32] = rnd_data;
            m_nb++;
         end
         if (in_valid && in_ready) begin
            inflight = 1'b1;
            m_data   = in_data;
            m_beats  = '0;
            m_nb     = 0;
            m_seen   = 1'b0;
         end
         if (out_valid && out_ready) begin
            inflight = 1'b0;
            words++;
         end
         @(negedge clk);
         cycles++;
      end
      check("rand_words_done", words, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
